// File: rtl/tile_pattern_writer.sv
// rtl/tile_pattern_writer.sv - raster frame filler emitting tiled color patterns to a video-RAM sink
//
// Purpose: on iStart, walks every pixel of an H_PIXELS x V_PIXELS frame in raster order,
// presenting one write beat per pixel with a color chosen from a latched two-color pattern.
// Beats advance only when the sink accepts (oWriteEnable & iWriteReady).
//
// Ports:
//   Clock, Reset            single clock, synchronous active-high reset
//   iStart, iAbort          start a fill (IDLE only) / terminate a fill (RUN only)
//   iMode, iColorA, iColorB pattern select and colors, latched at start
//   iWriteReady             sink accepts the current beat
//   oWriteEnable            beat valid
//   oCol, oRow, oColor      coordinate and color of the beat
//   oBusy, oDone            fill in progress / one-cycle completion pulse
module tile_pattern_writer #(
    parameter int H_PIXELS  = 256,
    parameter int V_PIXELS  = 256,
    parameter int COL_W     = 8,
    parameter int ROW_W     = 8,
    parameter int TILE_LOG2 = 6,
    parameter int COLOR_W   = 3
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               iStart,
    input  logic               iAbort,
    input  logic [1:0]         iMode,
    input  logic [COLOR_W-1:0] iColorA,
    input  logic [COLOR_W-1:0] iColorB,
    input  logic               iWriteReady,
    output logic               oWriteEnable,
    output logic [COL_W-1:0]   oCol,
    output logic [ROW_W-1:0]   oRow,
    output logic [COLOR_W-1:0] oColor,
    output logic               oBusy,
    output logic               oDone
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(H_PIXELS - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(V_PIXELS - 1);

    state_t             state_q, state_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [COLOR_W-1:0] color_q, color_d;
    logic               we_q, we_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [1:0]         mode_q, mode_d;
    logic [COLOR_W-1:0] color_a_q, color_a_d;
    logic [COLOR_W-1:0] color_b_q, color_b_d;

    logic               last_col;
    logic               last_row;
    logic [COL_W-1:0]   col_inc;
    logic [ROW_W-1:0]   row_inc;

    // Color for a coordinate; the color register is always loaded together with the
    // coordinate it belongs to, so oColor never lags oCol/oRow.
    function automatic logic [COLOR_W-1:0] pick_color(
        input logic [1:0]         mode,
        input logic [COLOR_W-1:0] ca,
        input logic [COLOR_W-1:0] cb,
        input logic [COL_W-1:0]   col,
        input logic [ROW_W-1:0]   row
    );
        logic tx;
        logic ty;
        logic use_b;
        tx = col[TILE_LOG2];
        ty = row[TILE_LOG2];
        case (mode)
            2'd0:    use_b = 1'b0;
            2'd1:    use_b = tx ^ ty;
            2'd2:    use_b = tx;
            default: use_b = ty;
        endcase
        return use_b ? cb : ca;
    endfunction

    // Next raster position; wraps explicitly so non-power-of-two sizes never overrun.
    always_comb begin
        last_col = (col_q == COL_LAST);
        last_row = (row_q == ROW_LAST);
        col_inc  = last_col ? '0 : col_q + 1'b1;
        row_inc  = last_col ? row_q + 1'b1 : row_q;
    end

    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        row_d     = row_q;
        color_d   = color_q;
        we_d      = we_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        mode_d    = mode_q;
        color_a_d = color_a_q;
        color_b_d = color_b_q;
        case (state_q)
            S_IDLE: begin
                if (iStart) begin
                    state_d   = S_RUN;
                    mode_d    = iMode;
                    color_a_d = iColorA;
                    color_b_d = iColorB;
                    col_d     = '0;
                    row_d     = '0;
                    color_d   = pick_color(iMode, iColorA, iColorB, '0, '0);
                    we_d      = 1'b1;
                    busy_d    = 1'b1;
                end
            end
            S_RUN: begin
                // Abort wins over completion; a beat accepted this cycle is already written.
                if (iAbort) begin
                    state_d = S_IDLE;
                    we_d    = 1'b0;
                    busy_d  = 1'b0;
                end else if (we_q && iWriteReady) begin
                    if (last_col && last_row) begin
                        state_d = S_DONE;
                        we_d    = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        col_d   = col_inc;
                        row_d   = row_inc;
                        color_d = pick_color(mode_q, color_a_q, color_b_q, col_inc, row_inc);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                we_d    = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            col_q     <= '0;
            row_q     <= '0;
            color_q   <= '0;
            we_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            mode_q    <= '0;
            color_a_q <= '0;
            color_b_q <= '0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            row_q     <= row_d;
            color_q   <= color_d;
            we_q      <= we_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            mode_q    <= mode_d;
            color_a_q <= color_a_d;
            color_b_q <= color_b_d;
        end
    end

    assign oWriteEnable = we_q;
    assign oCol         = col_q;
    assign oRow         = row_q;
    assign oColor       = color_q;
    assign oBusy        = busy_q;
    assign oDone        = done_q;

endmodule

// File: tb/tb_tile_pattern_writer.sv
// tb/tb_tile_pattern_writer.sv - self-checking bench for tile_pattern_writer
module tb_tile_pattern_writer;

    localparam int HA = 8;
    localparam int VA = 4;
    localparam int HB = 6;
    localparam int VB = 3;
    localparam int TL = 1;

    logic       Clock;
    logic       Reset;

    logic       iStart, iAbort, iWriteReady;
    logic [1:0] iMode;
    logic [2:0] iColorA, iColorB;
    logic       oWriteEnable, oBusy, oDone;
    logic [7:0] oCol, oRow;
    logic [2:0] oColor;

    logic       b_start, b_abort, b_ready;
    logic [1:0] b_mode;
    logic [2:0] b_color_a, b_color_b;
    logic       b_we, b_busy, b_done;
    logic [7:0] b_col, b_row;
    logic [2:0] b_color;

    int total = 0;
    int bad   = 0;

    tile_pattern_writer #(
        .H_PIXELS(HA), .V_PIXELS(VA), .COL_W(8), .ROW_W(8), .TILE_LOG2(TL), .COLOR_W(3)
    ) u_dut (
        .Clock(Clock), .Reset(Reset), .iStart(iStart), .iAbort(iAbort), .iMode(iMode),
        .iColorA(iColorA), .iColorB(iColorB), .iWriteReady(iWriteReady),
        .oWriteEnable(oWriteEnable), .oCol(oCol), .oRow(oRow), .oColor(oColor),
        .oBusy(oBusy), .oDone(oDone)
    );

    tile_pattern_writer #(
        .H_PIXELS(HB), .V_PIXELS(VB), .COL_W(8), .ROW_W(8), .TILE_LOG2(TL), .COLOR_W(3)
    ) u_dut_np2 (
        .Clock(Clock), .Reset(Reset), .iStart(b_start), .iAbort(b_abort), .iMode(b_mode),
        .iColorA(b_color_a), .iColorB(b_color_b), .iWriteReady(b_ready),
        .oWriteEnable(b_we), .oCol(b_col), .oRow(b_row), .oColor(b_color),
        .oBusy(b_busy), .oDone(b_done)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Reference pattern: tile index parity along each axis selects A or B.
    function automatic logic [2:0] model_color(input int mode, input logic [2:0] a,
                                               input logic [2:0] b, input int col, input int row);
        int tx;
        int ty;
        tx = (col / (1 << TL)) % 2;
        ty = (row / (1 << TL)) % 2;
        case (mode)
            0:       return a;
            1:       return (tx != ty) ? b : a;
            2:       return (tx == 1) ? b : a;
            default: return (ty == 1) ? b : a;
        endcase
    endfunction

    task automatic step;
        @(posedge Clock);
        #1;
    endtask

    // Runs one full frame on the 8x4 instance; beat k must be pixel (k%HA, k/HA).
    // ready_kind: 0 always ready, 1 toggle 1,0,..., 2 random. spam holds iStart high during RUN.
    task automatic drive_frame(input int mode, input logic [2:0] a, input logic [2:0] b,
                               input int ready_kind, input bit spam, output int edges);
        int  k;
        int  cyc;
        int  stalls;
        bit  rdy;
        k = 0; cyc = 0; stalls = 0;
        iStart = 1'b1; iMode = 2'(mode); iColorA = a; iColorB = b; iAbort = 1'b0;
        iWriteReady = 1'b0;
        step();
        edges = 0;
        iStart = spam;
        while (k < HA * VA && cyc < 400) begin
            iMode   = 2'($urandom);
            iColorA = 3'($urandom);
            iColorB = 3'($urandom);
            if (ready_kind == 0)      rdy = 1'b1;
            else if (ready_kind == 1) rdy = (cyc % 2 == 0);
            else                      rdy = 1'($urandom);
            iWriteReady = rdy;
            total++;
            if (oWriteEnable !== 1'b1 || oBusy !== 1'b1 || oDone !== 1'b0) begin
                bad++;
                $display("FAIL run_flags k=%0d got we/busy/done=%0b%0b%0b want 110", k,
                         oWriteEnable, oBusy, oDone);
            end
            total++;
            if (oCol !== 8'(k % HA) || oRow !== 8'(k / HA) ||
                oColor !== model_color(mode, a, b, k % HA, k / HA)) begin
                bad++;
                $display("FAIL beat k=%0d got col/row/color=%0d/%0d/%0d want %0d/%0d/%0d", k,
                         oCol, oRow, oColor, k % HA, k / HA,
                         model_color(mode, a, b, k % HA, k / HA));
            end
            step();
            edges++;
            cyc++;
            if (rdy) k++;
            else stalls++;
        end
        iStart = 1'b0;
        total++;
        if (k !== HA * VA) begin
            bad++;
            $display("FAIL frame_beats got %0d want %0d", k, HA * VA);
        end
        total++;
        if (oDone !== 1'b1 || oWriteEnable !== 1'b0 || oBusy !== 1'b0) begin
            bad++;
            $display("FAIL frame_done got done/we/busy=%0b%0b%0b want 100", oDone, oWriteEnable, oBusy);
        end
        total++;
        if (edges !== HA * VA + stalls) begin
            bad++;
            $display("FAIL done_latency got %0d want %0d", edges, HA * VA + stalls);
        end
        iStart = 1'b1;
        iWriteReady = 1'b1;
        step();
        iStart = 1'b0;
        total++;
        if (oDone !== 1'b0 || oBusy !== 1'b0 || oWriteEnable !== 1'b0) begin
            bad++;
            $display("FAIL done_one_cycle got done/busy/we=%0b%0b%0b want 000", oDone, oBusy, oWriteEnable);
        end
        step();
        total++;
        if (oBusy !== 1'b0 || oWriteEnable !== 1'b0) begin
            bad++;
            $display("FAIL start_in_done_ignored got busy/we=%0b%0b want 00", oBusy, oWriteEnable);
        end
    endtask

    task automatic test_reset;
        Reset = 1'b1;
        iStart = 1'b1; iAbort = 1'b1; b_start = 1'b1; b_abort = 1'b0;
        step();
        step();
        total++;
        if ({oWriteEnable, oBusy, oDone, oCol, oRow, oColor} !== '0) begin
            bad++;
            $display("FAIL reset_a got we=%0b busy=%0b done=%0b col=%0d row=%0d color=%0d want all 0",
                     oWriteEnable, oBusy, oDone, oCol, oRow, oColor);
        end
        total++;
        if ({b_we, b_busy, b_done, b_col, b_row, b_color} !== '0) begin
            bad++;
            $display("FAIL reset_b got we=%0b busy=%0b done=%0b col=%0d row=%0d color=%0d want all 0",
                     b_we, b_busy, b_done, b_col, b_row, b_color);
        end
        iStart = 1'b0; iAbort = 1'b0; b_start = 1'b0;
        Reset = 1'b0;
        step();
    endtask

    task automatic test_checker;
        int edges;
        drive_frame(1, 3'b111, 3'b001, 0, 1'b0, edges);
        total++;
        if (edges !== 32) begin
            bad++;
            $display("FAIL checker_done_edges got %0d want 32", edges);
        end
    endtask

    task automatic test_stall;
        int edges;
        drive_frame(2, 3'd4, 3'd2, 1, 1'b0, edges);
        total++;
        if (edges !== 63) begin
            bad++;
            $display("FAIL stall_done_edges got %0d want 63", edges);
        end
    endtask

    task automatic test_random_frames;
        int edges;
        for (int f = 0; f < 4; f++) begin
            drive_frame(int'($urandom_range(0, 3)), 3'($urandom), 3'($urandom), 2, 1'b1, edges);
        end
    endtask

    task automatic test_nonpow2;
        int k;
        int cyc;
        bit rdy;
        k = 0; cyc = 0;
        b_start = 1'b1; b_mode = 2'd3; b_color_a = 3'd6; b_color_b = 3'd1; b_abort = 1'b0;
        step();
        b_start = 1'b0;
        while (k < HB * VB && cyc < 200) begin
            b_mode = 2'($urandom); b_color_a = 3'($urandom); b_color_b = 3'($urandom);
            rdy = 1'($urandom);
            b_ready = rdy;
            total++;
            if (b_we !== 1'b1 || b_col !== 8'(k % HB) || b_row !== 8'(k / HB) ||
                b_color !== model_color(3, 3'd6, 3'd1, k % HB, k / HB)) begin
                bad++;
                $display("FAIL np2_beat k=%0d got we/col/row/color=%0b/%0d/%0d/%0d want 1/%0d/%0d/%0d",
                         k, b_we, b_col, b_row, b_color, k % HB, k / HB,
                         model_color(3, 3'd6, 3'd1, k % HB, k / HB));
            end
            step();
            cyc++;
            if (rdy) k++;
        end
        total++;
        if (k !== HB * VB || b_done !== 1'b1 || b_busy !== 1'b0) begin
            bad++;
            $display("FAIL np2_done got beats=%0d done=%0b busy=%0b want %0d 1 0", k, b_done, b_busy, HB * VB);
        end
        b_ready = 1'b0;
        step();
    endtask

    task automatic test_abort;
        bit saw_done;
        iStart = 1'b1; iMode = 2'd1; iColorA = 3'd5; iColorB = 3'd2; iWriteReady = 1'b1;
        step();
        iStart = 1'b0;
        for (int k = 0; k < 11; k++) step();
        total++;
        if (oCol !== 8'd3 || oRow !== 8'd1 || oColor !== model_color(1, 3'd5, 3'd2, 3, 1)) begin
            bad++;
            $display("FAIL abort_pos got col/row/color=%0d/%0d/%0d want 3/1/%0d", oCol, oRow, oColor,
                     model_color(1, 3'd5, 3'd2, 3, 1));
        end
        iAbort = 1'b1;
        step();
        iAbort = 1'b0;
        total++;
        if (oBusy !== 1'b0 || oWriteEnable !== 1'b0 || oDone !== 1'b0) begin
            bad++;
            $display("FAIL abort_stop got busy/we/done=%0b%0b%0b want 000", oBusy, oWriteEnable, oDone);
        end
        saw_done = 1'b0;
        iAbort = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            if (oDone === 1'b1 || oBusy === 1'b1) saw_done = 1'b1;
        end
        iAbort = 1'b0;
        total++;
        if (saw_done !== 1'b0) begin
            bad++;
            $display("FAIL abort_idle_quiet got activity=1 want 0");
        end
        // Start with iAbort also high: abort means nothing in IDLE.
        iStart = 1'b1; iAbort = 1'b1; iMode = 2'd0; iColorA = 3'd6; iColorB = 3'd3;
        step();
        iStart = 1'b0; iAbort = 1'b0;
        total++;
        if (oBusy !== 1'b1 || oWriteEnable !== 1'b1 || oCol !== 8'd0 || oRow !== 8'd0 || oColor !== 3'd6) begin
            bad++;
            $display("FAIL restart got busy/we/col/row/color=%0b/%0b/%0d/%0d/%0d want 1/1/0/0/6",
                     oBusy, oWriteEnable, oCol, oRow, oColor);
        end
        for (int k = 0; k < HA * VA - 1; k++) step();
        total++;
        if (oCol !== 8'(HA - 1) || oRow !== 8'(VA - 1) || oBusy !== 1'b1) begin
            bad++;
            $display("FAIL last_beat got col/row/busy=%0d/%0d/%0b want %0d/%0d/1", oCol, oRow, oBusy, HA - 1, VA - 1);
        end
        iAbort = 1'b1;
        step();
        iAbort = 1'b0;
        total++;
        if (oDone !== 1'b0 || oBusy !== 1'b0 || oWriteEnable !== 1'b0) begin
            bad++;
            $display("FAIL abort_priority got done/busy/we=%0b%0b%0b want 000", oDone, oBusy, oWriteEnable);
        end
        step();
    endtask

    task automatic test_reset_mid;
        bit saw_active;
        iStart = 1'b1; iMode = 2'd2; iColorA = 3'd7; iColorB = 3'd4; iWriteReady = 1'b1;
        step();
        iStart = 1'b0;
        for (int k = 0; k < 21; k++) step();
        total++;
        if (oCol !== 8'd5 || oRow !== 8'd2) begin
            bad++;
            $display("FAIL reset_mid_pos got col/row=%0d/%0d want 5/2", oCol, oRow);
        end
        Reset = 1'b1; iStart = 1'b1; iAbort = 1'b1;
        step();
        Reset = 1'b0; iStart = 1'b0; iAbort = 1'b0;
        total++;
        if ({oWriteEnable, oBusy, oDone, oCol, oRow, oColor} !== '0) begin
            bad++;
            $display("FAIL reset_mid got we=%0b busy=%0b done=%0b col=%0d row=%0d color=%0d want all 0",
                     oWriteEnable, oBusy, oDone, oCol, oRow, oColor);
        end
        saw_active = 1'b0;
        for (int c = 0; c < 40; c++) begin
            step();
            if (oDone === 1'b1 || oBusy === 1'b1 || oWriteEnable === 1'b1) saw_active = 1'b1;
        end
        total++;
        if (saw_active !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_quiet got activity=1 want 0");
        end
    endtask

    initial begin
        Reset = 1'b1;
        iStart = 1'b0; iAbort = 1'b0; iMode = 2'd0; iColorA = 3'd0; iColorB = 3'd0; iWriteReady = 1'b0;
        b_start = 1'b0; b_abort = 1'b0; b_mode = 2'd0; b_color_a = 3'd0; b_color_b = 3'd0; b_ready = 1'b0;
        step();
        test_reset();
        test_checker();
        test_stall();
        test_random_frames();
        test_nonpow2();
        test_abort();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
